pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the five-stage RV32 pipeline.
- Drives the stall and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch redirects, and instruction/data memory wait states.
- Generates the 3-bit debug tag stamped on each instruction accepted into IF/ID.

Parameters:
REG_WIDTH, 5, register index width
REDIRECT_CYCLES, 1, extra IF/ID flush cycles after a taken branch (0..7), covering in-flight synchronous fetches
PERF_WIDTH, 16, width of the stall performance counter

Ports:
i_Clock  in  1  clock, rising edge
i_Reset  in  1  asynchronous reset, active-low
i_IMemReady  in  1  fetch data valid this cycle
i_DMemReq  in  1  MEM stage holds a load/store
i_DMemReady  in  1  data memory completes this cycle
i_ID_RS1  in  REG_WIDTH  ID source register 1
i_ID_RS2  in  REG_WIDTH  ID source register 2
i_ID_UsesRS1  in  1  ID instruction reads RS1
i_ID_UsesRS2  in  1  ID instruction reads RS2
i_EX_MemRead  in  1  EX instruction is a load
i_EX_RD  in  REG_WIDTH  EX destination register
i_EX_BranchTaken  in  1  EX resolved taken branch/jump
o_PCStall  out  1  hold PC
o_IFID_Stall  out  1  hold IF/ID
o_IFID_Flush  out  1  load bubble into IF/ID
o_IDEX_Stall  out  1  hold ID/EX
o_IDEX_Flush  out  1  load bubble into ID/EX
o_EXMEM_Stall  out  1  hold EX/MEM
o_MEMWB_Flush  out  1  load bubble into MEM/WB
o_DbgTag  out  3  tag for instruction entering IF/ID
o_StallCount  out  PERF_WIDTH  saturating count of stalled cycles

Behaviour:
- Reset:
  - i_Reset low forces state=START, redirect counter=0, tag=0 and o_StallCount=0 asynchronously.
  - While i_Reset is low, outputs are o_PCStall=1, o_IFID_Flush=1, o_IDEX_Flush=1; all other outputs are 0.
- States: START, RUN, REDIRECT.
  - START lasts exactly 1 cycle after reset release: o_IFID_Flush=1, PC advances. Then go to RUN.
- Outputs are combinational from state and inputs. State, counters and tag are registered. The conditions below are evaluated in priority order in RUN/REDIRECT:
  1. DMEM wait (i_DMemReq & ~i_DMemReady): o_PCStall, o_IFID_Stall, o_IDEX_Stall, o_EXMEM_Stall = 1; o_MEMWB_Flush=1; all other flushes 0. State and redirect counter frozen. A pending branch stays held in EX and is serviced on release.
  2. Branch (i_EX_BranchTaken): o_IFID_Flush=1, o_IDEX_Flush=1, o_PCStall=0. Next state is REDIRECT with counter=REDIRECT_CYCLES, or RUN if REDIRECT_CYCLES=0. A branch taken while already in REDIRECT reloads the counter.
  3. REDIRECT with counter>0: o_IFID_Flush=1; counter decrements; go to RUN when it reaches 0 after the decrement. The load-use check is suppressed.
  4. Load-use:
     - Condition: i_EX_MemRead & i_EX_RD!=0 & ((i_ID_UsesRS1 & i_ID_RS1==i_EX_RD) | (i_ID_UsesRS2 & i_ID_RS2==i_EX_RD)).
     - Action: o_PCStall=1, o_IFID_Stall=1, o_IDEX_Flush=1. Lasts exactly one cycle, because the load leaves EX.
  5. IMEM wait (~i_IMemReady): o_PCStall=1, o_IFID_Flush=1. Downstream stages keep advancing.
  6. Otherwise all outputs are 0.
- Stall/flush exclusivity: a stall and a flush are never both 1 on the same register; the flush is dropped in that case.
- Tag:
  - Increments mod 8 on each rising edge where IF/ID accepts a real instruction: state RUN/REDIRECT, o_IFID_Stall=0 and o_IFID_Flush=0.
  - o_DbgTag presents the current value, so the accepted instruction carries it.
- Stall counter: increments on each cycle with o_PCStall=1 outside reset and START; saturates at all-ones.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef ctrl_state_t {START, RUN, REDIRECT};
  - struct stage_ctrl_t {stall, flush};
  - the x0 index constant (REG_ZERO).
- One sub-module: load_use_detector, combinational compare of ID sources against the EX destination.
- Everything else stays in this block.

Test Plan:
- Reset release then i_IMemReady=1 constantly -> cycle 0 o_IFID_Flush=1; from cycle 1 all outputs 0; o_DbgTag increments 0,1,...,7,0 each cycle.
- i_EX_MemRead=1, i_EX_RD=5, i_ID_RS2=5, i_ID_UsesRS2=1 for 1 cycle -> o_PCStall=o_IFID_Stall=o_IDEX_Flush=1 for exactly that cycle; tag not incremented.
- Same as previous but i_EX_RD=0 -> no stall.
- i_EX_BranchTaken=1 for 1 cycle with REDIRECT_CYCLES=2 -> o_IFID_Flush=1 for 3 consecutive cycles; o_IDEX_Flush=1 for the first cycle only; o_PCStall=0 throughout.
- i_DMemReq=1, i_DMemReady=0 for 4 cycles with i_EX_BranchTaken=1 -> all four stalls plus o_MEMWB_Flush held 4 cycles with no flushes; branch flush follows in cycle 5; o_StallCount=4.
- i_IMemReady=0 for 3 cycles -> o_PCStall=1, o_IFID_Flush=1, o_IDEX_Flush=0 for 3 cycles.
- Assert i_Reset low mid-REDIRECT -> immediate reset outputs; after release START behaviour; tag=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline control logic.
package pipeline_pkg;

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    localparam int REG_ZERO = 0;

    // A register that is held cannot also take a bubble; the hold wins.
    function automatic stage_ctrl_t resolve_stage(input stage_ctrl_t ctrl);
        stage_ctrl_t res;
        res.stall = ctrl.stall;
        res.flush = ctrl.flush & ~ctrl.stall;
        return res;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detector
    import pipeline_pkg::*;
#(
    parameter int REG_WIDTH = 5
) (
    input  logic [REG_WIDTH-1:0] i_ID_RS1,
    input  logic [REG_WIDTH-1:0] i_ID_RS2,
    input  logic                 i_ID_UsesRS1,
    input  logic                 i_ID_UsesRS2,
    input  logic                 i_EX_MemRead,
    input  logic [REG_WIDTH-1:0] i_EX_RD,
    output logic                 o_Hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = i_ID_UsesRS1 && (i_ID_RS1 == i_EX_RD);
    assign rs2_match = i_ID_UsesRS2 && (i_ID_RS2 == i_EX_RD);

    // x0 is hard-wired, so a load targeting it never creates a dependency.
    assign o_Hazard = i_EX_MemRead && (i_EX_RD != REG_WIDTH'(REG_ZERO)) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: memory waits, branch
// redirects, load-use bubbles, debug tag and stall performance counter.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int REG_WIDTH       = 5,
    parameter int REDIRECT_CYCLES = 1,
    parameter int PERF_WIDTH      = 16
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_IMemReady,
    input  logic                  i_DMemReq,
    input  logic                  i_DMemReady,
    input  logic [REG_WIDTH-1:0]  i_ID_RS1,
    input  logic [REG_WIDTH-1:0]  i_ID_RS2,
    input  logic                  i_ID_UsesRS1,
    input  logic                  i_ID_UsesRS2,
    input  logic                  i_EX_MemRead,
    input  logic [REG_WIDTH-1:0]  i_EX_RD,
    input  logic                  i_EX_BranchTaken,
    output logic                  o_PCStall,
    output logic                  o_IFID_Stall,
    output logic                  o_IFID_Flush,
    output logic                  o_IDEX_Stall,
    output logic                  o_IDEX_Flush,
    output logic                  o_EXMEM_Stall,
    output logic                  o_MEMWB_Flush,
    output logic [2:0]            o_DbgTag,
    output logic [PERF_WIDTH-1:0] o_StallCount
);

    localparam logic [2:0] REDIRECT_LOAD = 3'(REDIRECT_CYCLES);

    ctrl_state_t           state_reg, state_next;
    logic [2:0]            redirect_cnt_reg, redirect_cnt_next;
    logic [2:0]            tag_reg;
    logic [PERF_WIDTH-1:0] stall_cnt_reg;

    logic        load_use;
    logic        dmem_wait;
    logic        pc_stall;
    logic        exmem_stall;
    logic        memwb_flush;
    stage_ctrl_t ifid_raw, idex_raw;
    stage_ctrl_t ifid_ctrl, idex_ctrl;
    logic        ifid_accept;

    load_use_detector #(
        .REG_WIDTH(REG_WIDTH)
    ) u_load_use (
        .i_ID_RS1    (i_ID_RS1),
        .i_ID_RS2    (i_ID_RS2),
        .i_ID_UsesRS1(i_ID_UsesRS1),
        .i_ID_UsesRS2(i_ID_UsesRS2),
        .i_EX_MemRead(i_EX_MemRead),
        .i_EX_RD     (i_EX_RD),
        .o_Hazard    (load_use)
    );

    assign dmem_wait = i_DMemReq && !i_DMemReady;

    always_comb begin
        state_next        = state_reg;
        redirect_cnt_next = redirect_cnt_reg;
        pc_stall          = 1'b0;
        exmem_stall       = 1'b0;
        memwb_flush       = 1'b0;
        ifid_raw          = '0;
        idex_raw          = '0;

        if (!i_Reset) begin
            pc_stall       = 1'b1;
            ifid_raw.flush = 1'b1;
            idex_raw.flush = 1'b1;
        end else begin
            case (state_reg)
                START: begin
                    ifid_raw.flush = 1'b1;
                    state_next     = RUN;
                end
                default: begin
                    // Priority chain; a DMEM wait freezes everything, including a pending branch.
                    if (dmem_wait) begin
                        pc_stall       = 1'b1;
                        ifid_raw.stall = 1'b1;
                        idex_raw.stall = 1'b1;
                        exmem_stall    = 1'b1;
                        memwb_flush    = 1'b1;
                    end else if (i_EX_BranchTaken) begin
                        ifid_raw.flush = 1'b1;
                        idex_raw.flush = 1'b1;
                        if (REDIRECT_LOAD != 3'd0) begin
                            state_next        = REDIRECT;
                            redirect_cnt_next = REDIRECT_LOAD;
                        end else begin
                            state_next        = RUN;
                            redirect_cnt_next = 3'd0;
                        end
                    end else if (state_reg == REDIRECT && redirect_cnt_reg != 3'd0) begin
                        ifid_raw.flush    = 1'b1;
                        redirect_cnt_next = redirect_cnt_reg - 3'd1;
                        if (redirect_cnt_reg == 3'd1) begin
                            state_next = RUN;
                        end
                    end else if (load_use) begin
                        pc_stall       = 1'b1;
                        ifid_raw.stall = 1'b1;
                        idex_raw.flush = 1'b1;
                    end else if (!i_IMemReady) begin
                        pc_stall       = 1'b1;
                        ifid_raw.flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign ifid_ctrl = resolve_stage(ifid_raw);
    assign idex_ctrl = resolve_stage(idex_raw);

    assign o_PCStall     = pc_stall;
    assign o_IFID_Stall  = ifid_ctrl.stall;
    assign o_IFID_Flush  = ifid_ctrl.flush;
    assign o_IDEX_Stall  = idex_ctrl.stall;
    assign o_IDEX_Flush  = idex_ctrl.flush;
    assign o_EXMEM_Stall = exmem_stall;
    assign o_MEMWB_Flush = memwb_flush;
    assign o_DbgTag      = tag_reg;
    assign o_StallCount  = stall_cnt_reg;

    assign ifid_accept = (state_reg != START) && !ifid_ctrl.stall && !ifid_ctrl.flush;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_reg        <= START;
            redirect_cnt_reg <= 3'd0;
            tag_reg          <= 3'd0;
            stall_cnt_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            redirect_cnt_reg <= redirect_cnt_next;
            if (ifid_accept) begin
                tag_reg <= tag_reg + 3'd1;
            end
            if (state_reg != START && pc_stall && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + PERF_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller with two redirect cycles.
module tb_pipeline_hazard_controller;

    localparam logic [6:0] P_ZERO = 7'b0000000;
    localparam logic [6:0] P_RST  = 7'b1010100;
    localparam logic [6:0] P_IFFL = 7'b0010000;
    localparam logic [6:0] P_LU   = 7'b1100100;
    localparam logic [6:0] P_BR   = 7'b0010100;
    localparam logic [6:0] P_DM   = 7'b1101011;
    localparam logic [6:0] P_IM   = 7'b1010000;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_IMemReady;
    logic        i_DMemReq;
    logic        i_DMemReady;
    logic [4:0]  i_ID_RS1;
    logic [4:0]  i_ID_RS2;
    logic        i_ID_UsesRS1;
    logic        i_ID_UsesRS2;
    logic        i_EX_MemRead;
    logic [4:0]  i_EX_RD;
    logic        i_EX_BranchTaken;
    logic        o_PCStall;
    logic        o_IFID_Stall;
    logic        o_IFID_Flush;
    logic        o_IDEX_Stall;
    logic        o_IDEX_Flush;
    logic        o_EXMEM_Stall;
    logic        o_MEMWB_Flush;
    logic [2:0]  o_DbgTag;
    logic [15:0] o_StallCount;

    logic [6:0]  outs;
    logic [2:0]  exp_tag;
    int          checks;
    int          errors;

    assign outs = {o_PCStall, o_IFID_Stall, o_IFID_Flush, o_IDEX_Stall,
                   o_IDEX_Flush, o_EXMEM_Stall, o_MEMWB_Flush};

    pipeline_hazard_controller #(
        .REG_WIDTH      (5),
        .REDIRECT_CYCLES(2),
        .PERF_WIDTH     (16)
    ) dut (
        .i_Clock         (i_Clock),
        .i_Reset         (i_Reset),
        .i_IMemReady     (i_IMemReady),
        .i_DMemReq       (i_DMemReq),
        .i_DMemReady     (i_DMemReady),
        .i_ID_RS1        (i_ID_RS1),
        .i_ID_RS2        (i_ID_RS2),
        .i_ID_UsesRS1    (i_ID_UsesRS1),
        .i_ID_UsesRS2    (i_ID_UsesRS2),
        .i_EX_MemRead    (i_EX_MemRead),
        .i_EX_RD         (i_EX_RD),
        .i_EX_BranchTaken(i_EX_BranchTaken),
        .o_PCStall       (o_PCStall),
        .o_IFID_Stall    (o_IFID_Stall),
        .o_IFID_Flush    (o_IFID_Flush),
        .o_IDEX_Stall    (o_IDEX_Stall),
        .o_IDEX_Flush    (o_IDEX_Flush),
        .o_EXMEM_Stall   (o_EXMEM_Stall),
        .o_MEMWB_Flush   (o_MEMWB_Flush),
        .o_DbgTag        (o_DbgTag),
        .o_StallCount    (o_StallCount)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    task automatic check_outs(input string name, input logic [6:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s outs=%b expected=%b", name, outs, exp);
        end
    endtask

    task automatic check_tag(input string name, input logic [2:0] exp);
        checks++;
        assert (o_DbgTag === exp) else begin
            errors++;
            $error("FAIL %s_tag tag=%0d expected=%0d", name, o_DbgTag, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] exp);
        checks++;
        assert (o_StallCount === exp) else begin
            errors++;
            $error("FAIL %s_cnt count=%0d expected=%0d", name, o_StallCount, exp);
        end
    endtask

    task automatic idle_inputs();
        i_IMemReady      = 1'b1;
        i_DMemReq        = 1'b0;
        i_DMemReady      = 1'b0;
        i_ID_RS1         = 5'd0;
        i_ID_RS2         = 5'd0;
        i_ID_UsesRS1     = 1'b0;
        i_ID_UsesRS2     = 1'b0;
        i_EX_MemRead     = 1'b0;
        i_EX_RD          = 5'd0;
        i_EX_BranchTaken = 1'b0;
    endtask

    // Inputs are already applied; check, then advance one clock.
    task automatic step(input string name, input logic [6:0] exp, input bit accept);
        #1;
        check_outs(name, exp);
        check_tag(name, exp_tag);
        $display("step %-10s outs=%b tag=%0d count=%0d", name, outs, o_DbgTag, o_StallCount);
        @(posedge i_Clock);
        #2;
        if (accept) exp_tag = exp_tag + 3'd1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_tag = 3'd0;
        i_Reset = 1'b0;
        idle_inputs();

        #3;
        check_outs("reset", P_RST);
        check_tag("reset", 3'd0);
        check_cnt("reset", 16'd0);
        @(posedge i_Clock);
        #2;
        i_Reset = 1'b1;
        step("start", P_IFFL, 1'b0);

        for (int i = 0; i < 9; i++) begin
            step("idle", P_ZERO, 1'b1);
        end

        i_EX_MemRead = 1'b1; i_EX_RD = 5'd5; i_ID_RS2 = 5'd5; i_ID_UsesRS2 = 1'b1;
        step("lu_rs2", P_LU, 1'b0);
        idle_inputs();
        check_cnt("lu_rs2", 16'd1);
        step("after_lu", P_ZERO, 1'b1);

        i_EX_MemRead = 1'b1; i_EX_RD = 5'd0; i_ID_RS2 = 5'd0; i_ID_UsesRS2 = 1'b1;
        step("lu_x0", P_ZERO, 1'b1);

        idle_inputs();
        i_EX_MemRead = 1'b1; i_EX_RD = 5'd7; i_ID_RS1 = 5'd7; i_ID_UsesRS1 = 1'b1;
        step("lu_rs1", P_LU, 1'b0);
        check_cnt("lu_rs1", 16'd2);
        i_ID_UsesRS1 = 1'b0;
        step("lu_nouse", P_ZERO, 1'b1);

        idle_inputs();
        i_EX_BranchTaken = 1'b1;
        step("branch", P_BR, 1'b0);
        idle_inputs();
        step("redir1", P_IFFL, 1'b0);
        step("redir2", P_IFFL, 1'b0);
        step("run_a", P_ZERO, 1'b1);

        i_DMemReq = 1'b1; i_DMemReady = 1'b0; i_EX_BranchTaken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("dmem_wait", P_DM, 1'b0);
        end
        check_cnt("dmem_wait", 16'd6);
        i_DMemReady = 1'b1;
        step("br_release", P_BR, 1'b0);
        check_cnt("br_release", 16'd6);
        idle_inputs();
        i_EX_BranchTaken = 1'b1;
        step("br_reload", P_BR, 1'b0);
        idle_inputs();
        step("reload1", P_IFFL, 1'b0);
        step("reload2", P_IFFL, 1'b0);
        step("run_b", P_ZERO, 1'b1);

        i_IMemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("imem_wait", P_IM, 1'b0);
        end
        idle_inputs();
        check_cnt("imem_wait", 16'd9);
        step("run_c", P_ZERO, 1'b1);

        i_EX_BranchTaken = 1'b1;
        step("branch2", P_BR, 1'b0);
        idle_inputs();
        i_EX_MemRead = 1'b1; i_EX_RD = 5'd3; i_ID_RS1 = 5'd3; i_ID_UsesRS1 = 1'b1;
        step("lu_in_redir", P_IFFL, 1'b0);
        idle_inputs();
        check_cnt("lu_in_redir", 16'd9);
        step("redir_end", P_IFFL, 1'b0);
        step("run_d", P_ZERO, 1'b1);

        i_EX_BranchTaken = 1'b1;
        step("branch3", P_BR, 1'b0);
        idle_inputs();
        i_Reset = 1'b0;
        #1;
        check_outs("mid_reset", P_RST);
        check_tag("mid_reset", 3'd0);
        check_cnt("mid_reset", 16'd0);
        exp_tag = 3'd0;
        @(posedge i_Clock);
        #2;
        i_Reset = 1'b1;
        step("start2", P_IFFL, 1'b0);
        step("run_e", P_ZERO, 1'b1);
        #1;
        check_tag("final", exp_tag);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
